// File: rtl/apb_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : apb_pkg                                                        |
// | Purpose : Shared types and constants for the APB requester. Holds the    |
// |           requester state encoding, the default ACCESS timeout and a     |
// |           helper that sizes the timeout counter.                         |
// | Ports   : none (package)                                                 |
// | Rev     : 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
package apb_pkg;

   // Default number of ACCESS cycles before a transfer is abandoned.
   localparam int C_APB_TIMEOUT_DEFAULT = 256;

   typedef enum logic [1:0] {
      M_IDLE   = 2'd0,
      M_SETUP  = 2'd1,
      M_ACCESS = 2'd2,
      M_RESP   = 2'd3
   } apb_mst_states_t;

   // Counter width is $clog2(n+1). A disabled timeout (n == 0) still gets
   // one bit so the counter never collapses to a zero-width vector.
   function automatic int apb_cnt_width(input int n);
      int w;
      w = $clog2(n + 1);
      return (w < 1) ? 1 : w;
   endfunction

endpackage : apb_pkg
`default_nettype wire

// File: rtl/apb_master.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : apb_master                                                     |
// | Purpose : APB requester. Takes one read/write command at a time on a     |
// |           valid/ready command port, runs it as a SETUP -> ACCESS APB     |
// |           transfer (with wait states until pready) and returns read      |
// |           data plus timeout status on a valid/ready response port.      |
// | Ports   : clk, rst_n              clock / async active-low reset         |
// |           psel, penable, pwrite   APB control (registered outputs)       |
// |           paddr, pwdata           APB address / write data (registered)  |
// |           prdata, pready          APB read data / transfer complete      |
// |           cmd_valid, cmd_ready    command handshake                      |
// |           cmd_write/addr/wdata    command payload                        |
// |           rsp_valid, rsp_ready    response handshake                     |
// |           rsp_rdata, rsp_err      response payload                       |
// | Rev     : 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
module apb_master
   import apb_pkg::*;
#(
   parameter int ADDR_WIDTH     = 32,
   parameter int DATA_WIDTH     = 32,
   parameter int TIMEOUT_CYCLES = C_APB_TIMEOUT_DEFAULT
) (
   input  logic                  clk,
   input  logic                  rst_n,
   // APB pins
   output logic                  psel,
   output logic                  penable,
   output logic                  pwrite,
   output logic [ADDR_WIDTH-1:0] paddr,
   output logic [DATA_WIDTH-1:0] pwdata,
   input  logic [DATA_WIDTH-1:0] prdata,
   input  logic                  pready,
   // command port
   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   input  logic                  cmd_write,
   input  logic [ADDR_WIDTH-1:0] cmd_addr,
   input  logic [DATA_WIDTH-1:0] cmd_wdata,
   // response port
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [DATA_WIDTH-1:0] rsp_rdata,
   output logic                  rsp_err
);

   localparam int C_CNT_W = apb_cnt_width(TIMEOUT_CYCLES);

   // Counter value in the last ACCESS cycle that is still allowed to wait.
   localparam logic [C_CNT_W-1:0] C_TO_LAST =
      C_CNT_W'((TIMEOUT_CYCLES > 0) ? (TIMEOUT_CYCLES - 1) : 0);
   localparam logic [C_CNT_W-1:0] C_CNT_MAX = '1;
   localparam bit                 C_TO_EN   = (TIMEOUT_CYCLES > 0);

   apb_mst_states_t      r_state;
   logic [C_CNT_W-1:0]   r_cnt;
   logic                 w_timeout;

   // Ready only in idle and only once reset has been released, so a
   // command presented during reset is never considered accepted.
   assign cmd_ready = (r_state == M_IDLE) & rst_n;

   assign w_timeout = C_TO_EN && (r_cnt == C_TO_LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= M_IDLE;
         r_cnt     <= '0;
         psel      <= 1'b0;
         penable   <= 1'b0;
         pwrite    <= 1'b0;
         paddr     <= '0;
         pwdata    <= '0;
         rsp_valid <= 1'b0;
         rsp_rdata <= '0;
         rsp_err   <= 1'b0;
      end else begin
         case (r_state)
            M_IDLE: begin
               // cmd_ready is high whenever this branch runs.
               if (cmd_valid) begin
                  pwrite  <= cmd_write;
                  paddr   <= cmd_addr;
                  pwdata  <= cmd_wdata;
                  psel    <= 1'b1;
                  r_state <= M_SETUP;
               end
            end

            M_SETUP: begin
               penable <= 1'b1;
               r_state <= M_ACCESS;
            end

            M_ACCESS: begin
               // Completion is checked first so a slave answering in the
               // final allowed cycle still gets its data through.
               if (pready) begin
                  psel      <= 1'b0;
                  penable   <= 1'b0;
                  rsp_rdata <= pwrite ? '0 : prdata;
                  rsp_err   <= 1'b0;
                  rsp_valid <= 1'b1;
                  r_state   <= M_RESP;
               end else begin
                  if (w_timeout) begin
                     psel      <= 1'b0;
                     penable   <= 1'b0;
                     rsp_rdata <= '0;
                     rsp_err   <= 1'b1;
                     rsp_valid <= 1'b1;
                     r_state   <= M_RESP;
                  end
                  // Saturating so a disabled timeout never wraps around.
                  if (r_cnt != C_CNT_MAX) begin
                     r_cnt <= r_cnt + C_CNT_W'(1);
                  end
               end
            end

            M_RESP: begin
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  r_cnt     <= '0;
                  r_state   <= M_IDLE;
               end
            end

            default: begin
               r_state <= M_IDLE;
            end
         endcase
      end
   end

endmodule : apb_master
`default_nettype wire
